// File: rtl/traffic_light_ctrl_n.sv
// N-approach traffic-light controller: round-robin service of sensor requests with
// min/max green, timed yellow and all-red clearance, plus a maintenance flash mode.
module traffic_light_ctrl_n #(
    parameter int N_DIR     = 2,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int FLASH_T   = 3,
    localparam int AW       = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_DIR-1:0]   s,
    input  logic               flash,
    output logic [2*N_DIR-1:0] l,
    output logic [AW-1:0]      active,
    output logic [1:0]         phase
);

    localparam logic [1:0] ST_GREEN  = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_ALLRED = 2'b10;
    localparam logic [1:0] ST_FLASH  = 2'b11;

    localparam int T1   = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T2   = (ALLRED_T > FLASH_T) ? ALLRED_T : FLASH_T;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] GMIN_END = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_END = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_END  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_END   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] FL_END   = CW'(FLASH_T - 1);

    logic [1:0]       state;
    logic [AW-1:0]    cur;
    logic [AW-1:0]    nxt;
    logic [CW-1:0]    cnt;
    logic             blink;

    logic [N_DIR-1:0] cur_oh;
    logic             other_req;
    logic             s_cur;
    logic [AW-1:0]    pick_hi;
    logic [AW-1:0]    pick_lo;
    logic             found_hi;
    logic             found_lo;
    logic [AW-1:0]    pick;

    always_comb begin
        cur_oh = '0;
        for (int unsigned i = 0; i < N_DIR; i++) begin
            cur_oh[i] = (AW'(i) == cur);
        end
        other_req = |(s & ~cur_oh);
        s_cur     = |(s & cur_oh);
    end

    // Wrapping round-robin search: first requester above cur, else lowest below cur.
    always_comb begin
        pick_hi  = cur;
        pick_lo  = cur;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned j = 0; j < N_DIR; j++) begin
            if (!found_hi && s[j] && (AW'(j) > cur)) begin
                pick_hi  = AW'(j);
                found_hi = 1'b1;
            end
            if (!found_lo && s[j] && (AW'(j) < cur)) begin
                pick_lo  = AW'(j);
                found_lo = 1'b1;
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_GREEN;
            cur   <= '0;
            nxt   <= '0;
            cnt   <= '0;
            blink <= 1'b1;
        end else if (flash) begin
            if (state != ST_FLASH) begin
                state <= ST_FLASH;
                cnt   <= '0;
                blink <= 1'b1;
            end else if (cnt == FL_END) begin
                cnt   <= '0;
                blink <= ~blink;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            case (state)
                ST_GREEN: begin
                    if (other_req && (((cnt >= GMIN_END) && !s_cur) || (cnt >= GMAX_END))) begin
                        state <= ST_YELLOW;
                        nxt   <= pick;
                        cnt   <= '0;
                    end else if (cnt < GMAX_END) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_YELLOW: begin
                    if (cnt == YEL_END) begin
                        state <= ST_ALLRED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ALLRED: begin
                    if (cnt == AR_END) begin
                        state <= ST_GREEN;
                        cur   <= nxt;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    // Leaving flash: clear through all-red back onto the frozen approach.
                    state <= ST_ALLRED;
                    nxt   <= cur;
                    cnt   <= '0;
                    blink <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        l = '0;
        for (int unsigned i = 0; i < N_DIR; i++) begin
            case (state)
                ST_GREEN:  if (cur_oh[i]) l[2*i +: 2] = 2'b10;
                ST_YELLOW: if (cur_oh[i]) l[2*i +: 2] = 2'b01;
                ST_FLASH:  l[2*i +: 2] = blink ? 2'b01 : 2'b11;
                default:   l[2*i +: 2] = 2'b00;
            endcase
        end
        active = cur;
        phase  = state;
    end

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n: a two-approach instance driven from a
// vector table, and a four-approach instance checked for round-robin order and timing.
module tb_traffic_light_ctrl_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, flash2, act2;
    logic [1:0] s2, ph2;
    logic [3:0] l2;

    logic       rst4, flash4;
    logic [3:0] s4;
    logic [7:0] l4;
    logic [1:0] act4, ph4;

    traffic_light_ctrl_n #(
        .N_DIR(2), .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(3)
    ) dut2 (
        .clk(clk), .reset(rst2), .s(s2), .flash(flash2), .l(l2), .active(act2), .phase(ph2)
    );

    traffic_light_ctrl_n #(
        .N_DIR(4), .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(3)
    ) dut4 (
        .clk(clk), .reset(rst4), .s(s4), .flash(flash4), .l(l4), .active(act4), .phase(ph4)
    );

    typedef struct {
        logic [1:0] s;
        logic       fl;
        logic [3:0] l;
        logic       act;
        logic [1:0] ph;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void addn(input int n, input logic [1:0] s_, input logic fl_,
                                 input logic [3:0] l_, input logic a_, input logic [1:0] p_);
        vec_t v;
        v.s = s_; v.fl = fl_; v.l = l_; v.act = a_; v.ph = p_;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    int greens[$];
    int durs[$];
    int exp_seq[5] = '{0, 1, 3, 1, 3};
    int exp_dur[4] = '{4, 8, 8, 8};

    initial begin
        // Expected rows after each rising edge, starting from a fresh reset.
        addn(3, 2'b10, 1'b0, 4'b0010, 1'b0, 2'b00);  // min green on 0
        addn(2, 2'b10, 1'b0, 4'b0001, 1'b0, 2'b01);
        addn(1, 2'b10, 1'b0, 4'b0000, 1'b0, 2'b10);
        addn(2, 2'b10, 1'b0, 4'b1000, 1'b1, 2'b00);  // approach 1 rests
        addn(6, 2'b11, 1'b0, 4'b1000, 1'b1, 2'b00);  // max green on 1
        addn(2, 2'b11, 1'b0, 4'b0100, 1'b1, 2'b01);
        addn(1, 2'b11, 1'b0, 4'b0000, 1'b1, 2'b10);
        addn(8, 2'b11, 1'b0, 4'b0010, 1'b0, 2'b00);  // max green on 0
        addn(2, 2'b11, 1'b0, 4'b0001, 1'b0, 2'b01);
        addn(1, 2'b11, 1'b0, 4'b0000, 1'b0, 2'b10);
        addn(8, 2'b11, 1'b0, 4'b1000, 1'b1, 2'b00);
        addn(1, 2'b11, 1'b0, 4'b0100, 1'b1, 2'b01);
        addn(3, 2'b11, 1'b1, 4'b0101, 1'b1, 2'b11);  // flash from mid-yellow
        addn(3, 2'b11, 1'b1, 4'b1111, 1'b1, 2'b11);
        addn(1, 2'b11, 1'b1, 4'b0101, 1'b1, 2'b11);
        addn(1, 2'b11, 1'b0, 4'b0000, 1'b1, 2'b10);
        addn(1, 2'b11, 1'b0, 4'b1000, 1'b1, 2'b00);

        rst2 = 1'b1; s2 = '0; flash2 = 1'b0;
        rst4 = 1'b1; s4 = 4'b1010; flash4 = 1'b0;

        #2;
        chk("rst_l", l2, 4'b0010);
        chk("rst_phase", ph2, 2'b00);
        chk("rst_active", act2, 1'b0);
        tick();
        chk("rst_held_l", l2, 4'b0010);

        @(negedge clk) rst2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rest_l", l2, 4'b0010);
            chk("rest_phase", ph2, 2'b00);
        end

        @(negedge clk) rst2 = 1'b1;
        @(negedge clk) rst2 = 1'b0;
        foreach (tbl[i]) begin
            s2 = tbl[i].s;
            flash2 = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d_l", i), l2, tbl[i].l);
            chk($sformatf("vec%0d_active", i), act2, tbl[i].act);
            chk($sformatf("vec%0d_phase", i), ph2, tbl[i].ph);
        end

        // Async reset while in all-red must take effect before the next edge.
        flash2 = 1'b1;
        tick();
        flash2 = 1'b0;
        tick();
        chk("pre_rst_phase", ph2, 2'b10);
        chk("pre_rst_active", act2, 1'b1);
        #2 rst2 = 1'b1;
        #1;
        chk("async_rst_l", l2, 4'b0010);
        chk("async_rst_phase", ph2, 2'b00);
        chk("async_rst_active", act2, 1'b0);
        @(negedge clk) rst2 = 1'b0;

        // Four approaches, requests on 1 and 3 only.
        begin
            logic [1:0] prev_ph;
            int run;
            prev_ph = 2'b00;
            run = 1;
            greens.push_back(0);
            @(negedge clk) rst4 = 1'b0;
            for (int cyc = 0; cyc < 200 && greens.size() < 5; cyc++) begin
                tick();
                if (ph4 == 2'b00) begin
                    if (prev_ph != 2'b00) begin
                        greens.push_back(int'(act4));
                        run = 1;
                    end else begin
                        run++;
                    end
                    chk("n4_green_lamp", l4, 8'b10 << (2 * act4));
                end else if (prev_ph == 2'b00) begin
                    durs.push_back(run);
                end
                prev_ph = ph4;
            end
            chk("n4_done", greens.size(), 5);
            for (int i = 0; i < 5; i++)
                chk($sformatf("n4_seq%0d", i), (i < greens.size()) ? greens[i] : -1, exp_seq[i]);
            for (int i = 0; i < 4; i++)
                chk($sformatf("n4_dur%0d", i), (i < durs.size()) ? durs[i] : -1, exp_dur[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
